// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan monitor: segment codes, FSM state type,
// and the segment/anode decode helpers reused by the display driver self-check.
package sseg_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } sseg_state_e;

  // Blank and every non-hex pattern decode to 0 with err set.
  function automatic void seg_to_hex(input logic [6:0] seg, output logic [3:0] nib, output bit err);
    err = 1'b0;
    nib = 4'h0;
    case (seg)
      SEG_0:   nib = 4'h0;
      SEG_1:   nib = 4'h1;
      SEG_2:   nib = 4'h2;
      SEG_3:   nib = 4'h3;
      SEG_4:   nib = 4'h4;
      SEG_5:   nib = 4'h5;
      SEG_6:   nib = 4'h6;
      SEG_7:   nib = 4'h7;
      SEG_8:   nib = 4'h8;
      SEG_9:   nib = 4'h9;
      SEG_A:   nib = 4'hA;
      SEG_B:   nib = 4'hB;
      SEG_C:   nib = 4'hC;
      SEG_D:   nib = 4'hD;
      SEG_E:   nib = 4'hE;
      SEG_F:   nib = 4'hF;
      default: err = 1'b1;
    endcase
  endfunction

  // A digit is being shown only when exactly one anode is driven low.
  function automatic logic anode_legal(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

  function automatic logic [1:0] anode_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    case (an)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sseg_scan_decoder_if.sv
// Multiplexed seven-segment display lines (all active-low). The display driver is the
// master; monitors such as sseg_scan_decoder attach as slaves and only observe.
interface sseg_scan_decoder_if;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output an, output seg, output dp);
  modport slave  (input  an, input  seg, input  dp);
endinterface

// File: rtl/sseg_char_decode.sv
// Combinational segment-pattern to hex-nibble decoder; err flags blank or non-hex patterns.
module sseg_char_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       err
);

  bit err_b;

  always_comb begin
    nib   = 4'h0;
    err_b = 1'b0;
    seg_to_hex(seg, nib, err_b);
    err   = err_b;
  end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Receive-side monitor for a 4-digit scanned seven-segment display: reconstructs the
// shown 16-bit hex value and decimal points from the active-low an/seg/dp lines.
module sseg_scan_decoder
  import sseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sseg_scan_decoder_if.slave   disp,
  // Frame output has no backpressure: frame_valid is a single-cycle pulse and
  // value/dp_mask/frame_err hold the committed frame until the next pulse.
  output logic [15:0]          value,
  output logic [3:0]           dp_mask,
  output logic                 frame_valid,
  output logic                 frame_err,
  output logic                 stale,
  output sseg_state_e          state
);

  localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM    = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYCLES);

  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic [3:0]       an_lat;
  logic [3:0]       settle_cnt;
  logic [3:0]       settle_next;
  logic             settle_hit;
  logic             do_sample;
  logic [1:0]       samp_idx;
  logic [3:0]       dec_nib;
  logic             dec_err;
  logic [3:0][3:0]  staging;
  logic [3:0]       staging_dp;
  logic             staging_err;
  logic [3:0]       seen;
  logic [TW-1:0]    tcnt;

  // All decisions are made on registered copies of the display lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= 4'hF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= disp.an;
      seg_r <= disp.seg;
      dp_r  <= disp.dp;
    end
  end

  sseg_char_decode u_char_decode (
    .seg (seg_r),
    .nib (dec_nib),
    .err (dec_err)
  );

  assign settle_next = settle_cnt + 4'd1;
  assign settle_hit  = (settle_next >= SETTLE_LIM);
  assign do_sample   = (state == SETTLE) && (an_r == an_lat) && settle_hit;
  assign samp_idx    = anode_index(an_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT;
      settle_cnt <= 4'd0;
      an_lat     <= 4'hF;
    end else begin
      case (state)
        WAIT: begin
          if (anode_legal(an_r)) begin
            state      <= SETTLE;
            settle_cnt <= 4'd1;
            an_lat     <= an_r;
          end
        end
        SETTLE: begin
          if (an_r != an_lat) begin
            state      <= WAIT;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_next;
            if (settle_hit) state <= HOLD;
          end
        end
        HOLD: begin
          // A new digit always passes through WAIT so it gets a full settle window.
          if (an_r != an_lat) begin
            state      <= WAIT;
            settle_cnt <= 4'd0;
          end
        end
        default: begin
          state      <= WAIT;
          settle_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Staging and commit. A sample taken in the commit cycle starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging     <= '0;
      staging_dp  <= 4'h0;
      staging_err <= 1'b0;
      seen        <= 4'h0;
      value       <= 16'h0000;
      dp_mask     <= 4'h0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      if (do_sample) begin
        staging[samp_idx]    <= dec_nib;
        staging_dp[samp_idx] <= ~dp_r;
      end
      if (seen == 4'hF) begin
        value       <= staging;
        dp_mask     <= staging_dp;
        frame_err   <= staging_err;
        frame_valid <= 1'b1;
        seen        <= do_sample ? (4'b0001 << samp_idx) : 4'h0;
        staging_err <= do_sample & dec_err;
      end else begin
        frame_valid <= 1'b0;
        if (do_sample) begin
          seen[samp_idx] <= 1'b1;
          staging_err    <= staging_err | dec_err;
        end
      end
    end
  end

  // Saturating idle counter; stale flags a display that has stopped scanning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else if (do_sample) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else if (tcnt != TLIM) begin
      tcnt  <= tcnt + TW'(1);
      stale <= ((tcnt + TW'(1)) == TLIM);
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder: scans known frames onto the display lines and
// checks the reconstructed value, decimal points, error flag, stale flag and reset.
module tb_sseg_scan_decoder;
  import sseg_pkg::*;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        frame_valid;
  logic        frame_err;
  logic        stale;
  sseg_state_e state;

  sseg_scan_decoder_if bus ();

  sseg_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp        (bus.slave),
    .value       (value),
    .dp_mask     (dp_mask),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .stale       (stale),
    .state       (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment codes, indexed by nibble
  logic [6:0] seg_code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_asserts = 0;
  int n_fail    = 0;
  int fv_count  = 0;
  int fv_base;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, one posedge per dwell cycle.
  task automatic idle(input int n);
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_digit(input int idx, input logic [6:0] s, input logic dp_on, input int dwell);
    bus.an  = ~(4'b0001 << idx);
    bus.seg = s;
    bus.dp  = ~dp_on;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic scan_raw(input logic [27:0] codes, input logic [3:0] dpm, input int dwell,
                          input int gap, input bit rev);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = rev ? 3 - k : k;
      if (gap > 0) idle(gap);
      show_digit(i, codes[7*i +: 7], dpm[i], dwell);
    end
    idle(4);
  endtask

  function automatic logic [27:0] encode(input logic [15:0] v);
    logic [27:0] c;
    for (int i = 0; i < 4; i++) c[7*i +: 7] = seg_code[v[4*i +: 4]];
    return c;
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dpm,
                             input logic err);
    check({tag, "_fv_count"}, fv_count - fv_base, 1);
    check({tag, "_value"}, value, v);
    check({tag, "_dp_mask"}, dp_mask, dpm);
    check({tag, "_frame_err"}, frame_err, err);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_value"}, value, 16'h0000);
    check({tag, "_dp_mask"}, dp_mask, 4'h0);
    check({tag, "_frame_valid"}, frame_valid, 1'b0);
    check({tag, "_frame_err"}, frame_err, 1'b0);
    check({tag, "_stale"}, stale, 1'b0);
    check({tag, "_state"}, state, WAIT);
  endtask

  initial begin
    logic [27:0] codes;

    rst_n   = 1'b0;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");

    // Plain frame, 8-cycle refresh slots
    fv_base = fv_count;
    scan_raw(encode(16'h1234), 4'b0000, 8, 0, 1'b0);
    check_frame("f1234", 16'h1234, 4'b0000, 1'b0);

    fv_base = fv_count;
    scan_raw(encode(16'hABCD), 4'b0100, 8, 0, 1'b0);
    check_frame("fabcd", 16'hABCD, 4'b0100, 1'b0);

    // Dwell shorter than the settle window never samples
    fv_base = fv_count;
    scan_raw(encode(16'hFFFF), 4'b1111, 3, 2, 1'b0);
    check("dwell3_no_frame", fv_count - fv_base, 0);
    check("dwell3_value_kept", value, 16'hABCD);

    // Dwell of exactly the settle window samples; three digits do not make a frame
    codes = encode(16'h5678);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      show_digit(i, codes[7*i +: 7], 1'b0, 4);
    end
    idle(4);
    check("dwell4_partial_no_frame", fv_count - fv_base, 0);
    idle(2);
    show_digit(3, codes[21 +: 7], 1'b0, 4);
    idle(4);
    check_frame("dwell4", 16'h5678, 4'b0000, 1'b0);

    // Blank pattern on digit 1 is a decode error
    fv_base = fv_count;
    codes = encode(16'h8888);
    codes[7 +: 7] = 7'h7F;
    scan_raw(codes, 4'b0000, 8, 0, 1'b0);
    check_frame("blank_err", 16'h8808, 4'b0000, 1'b1);

    fv_base = fv_count;
    scan_raw(encode(16'h0F9E), 4'b1001, 8, 0, 1'b0);
    check_frame("clean_after_err", 16'h0F9E, 4'b1001, 1'b0);

    // Stale after a long idle, value kept, cleared by the next sample
    fv_base = fv_count;
    idle(100);
    check("stale_not_yet", stale, 1'b0);
    idle(TIMEOUT);
    check("stale_set", stale, 1'b1);
    check("stale_value_kept", value, 16'h0F9E);
    check("stale_no_frame", fv_count - fv_base, 0);
    codes = encode(16'h4321);
    show_digit(0, codes[0 +: 7], 1'b0, 8);
    check("stale_cleared", stale, 1'b0);
    for (int i = 1; i < 4; i++) show_digit(i, codes[7*i +: 7], 1'b0, 8);
    idle(4);
    check_frame("resume", 16'h4321, 4'b0000, 1'b0);

    // Reset after two digits discards the partial frame
    show_digit(0, seg_code[9], 1'b1, 8);
    show_digit(1, seg_code[9], 1'b1, 8);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    fv_base = fv_count;
    scan_raw(encode(16'h2468), 4'b0010, 8, 0, 1'b1);
    check_frame("post_reset", 16'h2468, 4'b0010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
